// File: rtl/lane_mover_pkg.sv
// lane_mover_pkg: shared speed/state enums, screen bounds and default dividers
package lane_mover_pkg;
  typedef enum logic [1:0] {SPD_SLOW, SPD_FAST, SPD_TURBO, SPD_FROZEN} speed_e;
  typedef enum logic [1:0] {RUN, HOLD, FROZEN} lane_state_e;
  localparam int SCREEN_X_MIN = 191;
  localparam int SCREEN_X_MAX = 431;
  localparam int DEF_DIV_SLOW = 1000000;
  localparam int DEF_DIV_FAST = 250000;
  localparam int DEF_DIV_TURBO = 62500;
endpackage

// File: rtl/lane_mover_if.sv
// lane_mover_if: stage controller to lane mover control inputs and car position outputs
interface lane_mover_if #(
  parameter int NUM_CARS = 3,
  parameter int POS_W = 10
);
  logic [POS_W-1:0] start_x;
  logic [1:0] speed_sel;
  logic pause;
  logic restart;
  logic [NUM_CARS*POS_W-1:0] car_x;
  logic [POS_W-1:0] car_y;
  logic step_pulse;
  logic lane_active;
  modport master (output start_x, speed_sel, pause, restart, input car_x, car_y, step_pulse, lane_active);
  modport slave (input start_x, speed_sel, pause, restart, output car_x, car_y, step_pulse, lane_active);
endinterface

// File: rtl/lane_mover_car_pos_step.sv
// car_pos_step: combinational next X of one car, wrapping exactly onto the opposite bound
module car_pos_step #(
  parameter int POS_W = 10,
  parameter int X_MIN = 191,
  parameter int X_MAX = 431,
  parameter int DIR = 0,
  parameter int STEP = 1
) (
  input logic [POS_W-1:0] x,
  output logic [POS_W-1:0] next_x
);
  localparam logic [POS_W:0] STEP_E = (POS_W+1)'(STEP);
  localparam logic [POS_W:0] MAX_E = (POS_W+1)'(X_MAX);
  localparam logic [POS_W:0] LO_E = (POS_W+1)'(X_MIN + STEP);
  localparam logic [POS_W-1:0] MIN_X = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] MAX_X = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] STEP_X = POS_W'(STEP);
  always_comb
    next_x = (DIR != 0) ? (({1'b0, x} < LO_E) ? MAX_X : x - STEP_X)
                        : (({1'b0, x} + STEP_E > MAX_E) ? MIN_X : x + STEP_X);
endmodule

// File: rtl/lane_mover.sv
// lane_mover: moves NUM_CARS equally spaced cars along one lane with speed, pause and restart
module lane_mover
  import lane_mover_pkg::*;
#(
  parameter int NUM_CARS = 3,
  parameter int POS_W = 10,
  parameter int CNT_W = 22,
  parameter int X_MIN = SCREEN_X_MIN,
  parameter int X_MAX = SCREEN_X_MAX,
  parameter int Y_POS = 278,
  parameter int DIR = 0,
  parameter int SPACING = 80,
  parameter int X_START = 191,
  parameter int STEP = 1,
  parameter int DIV_SLOW = DEF_DIV_SLOW,
  parameter int DIV_FAST = DEF_DIV_FAST,
  parameter int DIV_TURBO = DEF_DIV_TURBO
) (
  input logic frame_clk,
  input logic Reset_n,
  lane_mover_if.slave bus
);
  if (X_START + (NUM_CARS-1)*SPACING > X_MAX) begin : g_bad_start
    $error("lane_mover: cars do not fit between X_START and X_MAX");
  end
  if (STEP >= X_MAX - X_MIN) begin : g_bad_step
    $error("lane_mover: STEP must be smaller than the lane width");
  end
  if (DIV_SLOW < 1 || DIV_FAST < 1 || DIV_TURBO < 1 ||
      longint'(DIV_SLOW) >= (64'd1 << CNT_W) || longint'(DIV_FAST) >= (64'd1 << CNT_W) ||
      longint'(DIV_TURBO) >= (64'd1 << CNT_W)) begin : g_bad_div
    $error("lane_mover: divider out of range for CNT_W");
  end
  localparam logic [POS_W:0] MAX_E = (POS_W+1)'(X_MAX);
  localparam logic [POS_W:0] SPAN_E = (POS_W+1)'(X_MAX - X_MIN + 1);
  lane_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_m1;
  logic [POS_W-1:0] x_q [NUM_CARS];
  logic [POS_W-1:0] nx [NUM_CARS];
  logic [POS_W-1:0] ld [NUM_CARS];
  logic [POS_W-1:0] s;
  logic pulse_q;
  logic frozen;
  logic hit;
  assign frozen = bus.speed_sel == SPD_FROZEN;
  assign div_m1 = (bus.speed_sel == SPD_FAST) ? CNT_W'(DIV_FAST - 1)
                : (bus.speed_sel == SPD_TURBO) ? CNT_W'(DIV_TURBO - 1) : CNT_W'(DIV_SLOW - 1);
  // >= rather than == so a mid-count switch to a faster speed steps at once
  assign hit = cnt_q >= div_m1;
  assign s = (bus.start_x < POS_W'(X_MIN) || bus.start_x > POS_W'(X_MAX)) ? POS_W'(X_MIN) : bus.start_x;
  for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
    localparam logic [POS_W:0] OFF = (POS_W+1)'(i*SPACING);
    logic [POS_W:0] sum;
    car_pos_step #(.POS_W(POS_W), .X_MIN(X_MIN), .X_MAX(X_MAX), .DIR(DIR), .STEP(STEP)) u_step (
      .x(x_q[i]),
      .next_x(nx[i])
    );
    assign sum = {1'b0, s} + OFF;
    assign ld[i] = (sum > MAX_E) ? POS_W'(sum - SPAN_E) : POS_W'(sum);
    assign bus.car_x[i*POS_W +: POS_W] = x_q[i];
  end
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= RUN;
      cnt_q <= '0;
      pulse_q <= 1'b0;
      for (int k = 0; k < NUM_CARS; k++) x_q[k] <= POS_W'(X_START + k*SPACING);
    end else if (bus.restart) begin
      state_q <= bus.pause ? HOLD : (frozen ? FROZEN : RUN);
      cnt_q <= '0;
      pulse_q <= 1'b0;
      x_q <= ld;
    end else if (bus.pause) begin
      state_q <= HOLD;
      pulse_q <= 1'b0;
    end else if (frozen) begin
      state_q <= FROZEN;
      cnt_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= RUN;
      cnt_q <= hit ? '0 : cnt_q + 1'b1;
      pulse_q <= hit;
      if (hit) x_q <= nx;
    end
  assign bus.car_y = POS_W'(Y_POS);
  assign bus.step_pulse = pulse_q;
  assign bus.lane_active = state_q == RUN;
endmodule

// File: tb/tb_lane_mover.sv
// tb_lane_mover: scoreboard bench for lane_mover (one right-moving and one left-moving lane)
module tb_lane_mover;
  localparam int W = 10;
  typedef struct {
    int cyc;
    logic [3*W-1:0] x;
  } exp_t;
  logic frame_clk = 1'b0;
  logic Reset_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t sbq[$];
  exp_t e;
  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) cyc <= cyc + 1;
  lane_mover_if #(.NUM_CARS(3), .POS_W(W)) bus_a ();
  lane_mover_if #(.NUM_CARS(3), .POS_W(W)) bus_b ();
  lane_mover #(.DIV_SLOW(8), .DIV_FAST(4), .DIV_TURBO(2)) dut_a (
    .frame_clk(frame_clk),
    .Reset_n(Reset_n),
    .bus(bus_a)
  );
  lane_mover #(.DIV_SLOW(8), .DIV_FAST(4), .DIV_TURBO(2), .DIR(1)) dut_b (
    .frame_clk(frame_clk),
    .Reset_n(Reset_n),
    .bus(bus_b)
  );
  function automatic logic [3*W-1:0] pk(int a, int b, int c);
    return {W'(c), W'(b), W'(a)};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic expect_step(int n, int a, int b, int c);
    sbq.push_back('{cyc + n, pk(a, b, c)});
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge frame_clk);
  endtask
  always @(negedge frame_clk)
    if (Reset_n) begin
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL step_missing actual=none required=pulse at cyc %0d (now %0d)", sbq[0].cyc, cyc);
        void'(sbq.pop_front());
      end
      if (bus_a.step_pulse) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL step_unexpected actual=pulse at cyc %0d car_x=%0h required=no pulse", cyc, bus_a.car_x);
        end else begin
          e = sbq.pop_front();
          if (e.cyc != cyc || e.x !== bus_a.car_x) begin
            failures++;
            $display("FAIL step_pos actual=cyc %0d car_x=%0h required=cyc %0d car_x=%0h", cyc, bus_a.car_x, e.cyc, e.x);
          end
        end
      end
    end
  initial begin
    bus_a.start_x = '0;
    bus_a.speed_sel = 2'd0;
    bus_a.pause = 1'b0;
    bus_a.restart = 1'b0;
    bus_b.start_x = '0;
    bus_b.speed_sel = 2'd0;
    bus_b.pause = 1'b0;
    bus_b.restart = 1'b0;
    tick(2);
    chk("reset_car_x", 32'(bus_a.car_x), 32'(pk(191, 271, 351)));
    chk("reset_pulse", 32'(bus_a.step_pulse), 32'd0);
    chk("reset_active", 32'(bus_a.lane_active), 32'd1);
    chk("car_y", 32'(bus_a.car_y), 32'd278);
    chk("reset_b_car_x", 32'(bus_b.car_x), 32'(pk(191, 271, 351)));
    Reset_n = 1'b1;
    expect_step(8, 192, 272, 352);
    tick(7);
    chk("b_no_step_yet", 32'(bus_b.car_x), 32'(pk(191, 271, 351)));
    tick(1);
    chk("b_left_wrap", 32'(bus_b.car_x), 32'(pk(431, 270, 350)));
    chk("b_pulse", 32'(bus_b.step_pulse), 32'd1);
    tick(5);
    bus_a.speed_sel = 2'd1;
    expect_step(1, 193, 273, 353);
    expect_step(5, 194, 274, 354);
    tick(5);
    bus_a.speed_sel = 2'd0;
    tick(4);
    bus_a.pause = 1'b1;
    tick(20);
    chk("pause_active", 32'(bus_a.lane_active), 32'd0);
    chk("pause_hold_x", 32'(bus_a.car_x), 32'(pk(194, 274, 354)));
    bus_a.pause = 1'b0;
    expect_step(4, 195, 275, 355);
    tick(4);
    chk("resume_active", 32'(bus_a.lane_active), 32'd1);
    tick(3);
    bus_a.speed_sel = 2'd3;
    tick(1);
    chk("frozen_active", 32'(bus_a.lane_active), 32'd0);
    tick(5);
    chk("frozen_hold_x", 32'(bus_a.car_x), 32'(pk(195, 275, 355)));
    bus_a.speed_sel = 2'd2;
    expect_step(2, 196, 276, 356);
    expect_step(4, 197, 277, 357);
    tick(4);
    bus_a.start_x = 10'd420;
    bus_a.restart = 1'b1;
    tick(1);
    bus_a.restart = 1'b0;
    chk("restart_load", 32'(bus_a.car_x), 32'(pk(420, 259, 339)));
    chk("restart_pulse", 32'(bus_a.step_pulse), 32'd0);
    chk("restart_active", 32'(bus_a.lane_active), 32'd1);
    for (int k = 1; k <= 11; k++) expect_step(2*k, 420 + k, 259 + k, 339 + k);
    expect_step(24, 191, 271, 351);
    tick(24);
    tick(1);
    bus_a.start_x = 10'd100;
    bus_a.restart = 1'b1;
    bus_a.pause = 1'b1;
    tick(1);
    bus_a.restart = 1'b0;
    bus_a.pause = 1'b0;
    chk("restart_clamp", 32'(bus_a.car_x), 32'(pk(191, 271, 351)));
    chk("restart_over_step", 32'(bus_a.step_pulse), 32'd0);
    chk("restart_to_hold", 32'(bus_a.lane_active), 32'd0);
    expect_step(2, 192, 272, 352);
    tick(3);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_reset_a", 32'(bus_a.car_x), 32'(pk(191, 271, 351)));
    chk("async_reset_b", 32'(bus_b.car_x), 32'(pk(191, 271, 351)));
    chk("async_reset_active", 32'(bus_a.lane_active), 32'd1);
    chk("async_reset_pulse", 32'(bus_a.step_pulse), 32'd0);
    tick(2);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
